// File: rtl/dbg_dmi_pkg.sv
// Shared DMI op codes, DM register addresses and the
// DTM-side access sequencer state encoding.
package dbg_dmi_pkg;

    localparam logic [1:0] OP_NOP = 2'd0;
    localparam logic [1:0] OP_RD  = 2'd1;
    localparam logic [1:0] OP_WR  = 2'd2;
    localparam logic [1:0] OP_RSV = 2'd3;

    localparam logic [1:0] RSP_OK   = 2'd0;
    localparam logic [1:0] RSP_FAIL = 2'd2;
    localparam logic [1:0] RSP_BUSY = 2'd3;

    localparam logic [6:0] ADDR_DATA0     = 7'h04;
    localparam logic [6:0] ADDR_DMCONTROL = 7'h10;
    localparam logic [6:0] ADDR_DMSTATUS  = 7'h11;
    localparam logic [6:0] ADDR_COMMAND   = 7'h17;
    localparam logic [6:0] ADDR_SBDATA0   = 7'h3C;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } dmi_state_e;

    function automatic logic op_is_access(input logic [1:0] op);
        return (op == OP_RD) || (op == OP_WR);
    endfunction

endpackage

// File: rtl/dmi_access_ctrl.sv
// DTM-side DMI access sequencer: one DM access per request,
// registered strobes, sticky busy/failed response state.
module dmi_access_ctrl
    import dbg_dmi_pkg::*;
#(
    parameter int unsigned READ_LAT = 2
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        REQ_VALID,
    input  logic [1:0]  REQ_OP,
    input  logic [6:0]  REQ_AD,
    input  logic [31:0] REQ_DATA,
    input  logic        DMIRESET,
    input  logic        DMIHARDRESET,
    output logic [1:0]  RSP_OP,
    output logic [31:0] RSP_DATA,
    output logic        BUSY,
    output logic        DMI_CS,
    output logic        DMI_WR,
    output logic        DMI_RD,
    output logic [6:0]  DMI_AD,
    output logic [31:0] DMI_DI,
    input  logic [31:0] DMI_DO
);

    localparam logic [2:0] CNT_INIT = 3'(READ_LAT - 1);

    dmi_state_e  state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [1:0]  err_q, err_d;
    logic        is_rd_q, is_rd_d;
    logic        busy_q, busy_d;
    logic [1:0]  rsp_op_q, rsp_op_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        cs_q, cs_d;
    logic        wr_q, wr_d;
    logic        rd_q, rd_d;
    logic [6:0]  ad_q, ad_d;
    logic [31:0] di_q, di_d;
    logic [1:0]  err_clr;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_rd_d    = is_rd_q;
        rsp_op_d   = rsp_op_q;
        rsp_data_d = rsp_data_q;
        ad_d       = ad_q;
        di_d       = di_q;
        cs_d       = 1'b0;
        wr_d       = 1'b0;
        rd_d       = 1'b0;
        err_clr    = DMIRESET ? RSP_OK : err_q;
        err_d      = err_clr;

        if (DMIHARDRESET) begin
            state_d    = ST_IDLE;
            cnt_d      = 3'd0;
            err_d      = RSP_OK;
            rsp_op_d   = RSP_OK;
            rsp_data_d = 32'd0;
        end else begin
            // a request arriving mid-access is dropped but poisons the response
            if (state_q != ST_IDLE && REQ_VALID && err_clr == RSP_OK) begin
                err_d = RSP_BUSY;
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (REQ_VALID) begin
                        if (err_clr != RSP_OK) begin
                            rsp_op_d = err_clr;
                        end else if (op_is_access(REQ_OP)) begin
                            ad_d    = REQ_AD;
                            is_rd_d = (REQ_OP == OP_RD);
                            cs_d    = 1'b1;
                            rd_d    = (REQ_OP == OP_RD);
                            wr_d    = (REQ_OP == OP_WR);
                            if (REQ_OP == OP_WR) begin
                                di_d = REQ_DATA;
                            end
                            state_d = ST_ISSUE;
                        end else if (REQ_OP == OP_NOP) begin
                            rsp_op_d = RSP_OK;
                        end else begin
                            err_d    = RSP_FAIL;
                            rsp_op_d = RSP_FAIL;
                        end
                    end
                end
                ST_ISSUE: begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_INIT;
                end
                ST_WAIT: begin
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q == 3'd0) begin
                        state_d  = ST_IDLE;
                        cnt_d    = 3'd0;
                        rsp_op_d = err_d;
                        if (is_rd_q) begin
                            rsp_data_d = DMI_DO;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = 3'd0;
                end
            endcase
        end
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 3'd0;
            err_q      <= RSP_OK;
            is_rd_q    <= 1'b0;
            busy_q     <= 1'b0;
            rsp_op_q   <= RSP_OK;
            rsp_data_q <= 32'd0;
            cs_q       <= 1'b0;
            wr_q       <= 1'b0;
            rd_q       <= 1'b0;
            ad_q       <= 7'd0;
            di_q       <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            is_rd_q    <= is_rd_d;
            busy_q     <= busy_d;
            rsp_op_q   <= rsp_op_d;
            rsp_data_q <= rsp_data_d;
            cs_q       <= cs_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            ad_q       <= ad_d;
            di_q       <= di_d;
        end
    end

    assign RSP_OP   = rsp_op_q;
    assign RSP_DATA = rsp_data_q;
    assign BUSY     = busy_q;
    assign DMI_CS   = cs_q;
    assign DMI_WR   = wr_q;
    assign DMI_RD   = rd_q;
    assign DMI_AD   = ad_q;
    assign DMI_DI   = di_q;

endmodule
